rom_stream_reader: RTL and testbench

Parametrised successor to the single-purpose ROM address counter. It streams a programmable window of a synchronous block ROM (base address, word count, optional looping) onto a valid/ready stream with full backpressure support. It also accounts for the ROM's read latency. It sits between the weight/input ROMs (blk_mem_gen instances) and the neural-network datapath. One instance drives one ROM port.

---
 rtl/rom_stream_reader_if.sv | 20 ++
 rtl/rom_stream_reader.sv | 185 ++++++++++++++++++
 tb/tb_rom_stream_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// ----------------------------------------------------------------------------
// rom_stream_reader_if : valid/ready output stream carrying ROM words
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface rom_stream_reader_if #(
  parameter int DATA_W = 8
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

`default_nettype wire

// File: rtl/rom_stream_reader.sv
// ----------------------------------------------------------------------------
// rom_stream_reader : streams a base/length window of a synchronous ROM onto
//                     a valid/ready stream, with looping and abort.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module rom_stream_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int FIFO_D = RD_LAT + 2
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start_i,
  input  wire logic                stop_i,
  input  wire logic [ADDR_W-1:0]   base_addr_i,
  input  wire logic [ADDR_W:0]     length_i,
  input  wire logic                loop_i,
  output logic                     mem_en_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  wire logic [DATA_W-1:0]   mem_dout_i,
  output logic                     busy_o,
  output logic                     done_o,
  rom_stream_reader_if.master      m_if
);

  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = $clog2(FIFO_D + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;

  logic [RD_LAT-1:0] vld_pipe_q, last_pipe_q;
  logic [CNT_W-1:0]  inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] data_mem_q [FIFO_D];
  logic [FIFO_D-1:0] last_mem_q;

  logic credit, issue, issue_last, ret, pop, flush, out_valid, out_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  // Credit covers both words in the FIFO and reads still inside the ROM pipe.
  assign credit     = ({1'b0, inflight_q} + {1'b0, count_q}) < (CNT_W + 1)'(FIFO_D);
  assign issue      = (state_q == S_RUN) && !stop_i && credit;
  assign issue_last = issue && (rem_q == (ADDR_W + 1)'(1));
  assign ret        = vld_pipe_q[RD_LAT-1];
  assign flush      = stop_i && (state_q != S_IDLE);
  assign out_valid  = (count_q != '0);
  assign out_last   = out_valid && last_mem_q[rd_ptr_q];
  assign pop        = out_valid && m_if.m_ready;

  assign mem_en_o    = issue;
  assign mem_addr_o  = addr_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign m_if.m_valid = out_valid;
  assign m_if.m_data  = out_valid ? data_mem_q[rd_ptr_q] : '0;
  assign m_if.m_last  = out_last;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    base_d  = base_q;
    len_d   = len_q;
    rem_d   = rem_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (length_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_RUN;
            addr_d  = base_addr_i;
            base_d  = base_addr_i;
            len_d   = length_i;
            rem_d   = length_i;
            loop_d  = loop_i;
          end
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (issue_last) begin
          if (loop_q) begin
            addr_d = base_q;
            rem_d  = len_q;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (issue) begin
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
        end
      end
      S_DRAIN: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (pop && out_last) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  // Clearing the pipe tags on abort makes any late ROM return fall on the floor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else if (flush) begin
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      vld_pipe_q[0]  <= issue;
      last_pipe_q[0] <= issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1];
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      inflight_q <= inflight_q + CNT_W'(issue) - CNT_W'(ret);
      if (ret) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(ret) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (ret && !flush) begin
      data_mem_q[wr_ptr_q] <= mem_dout_i;
      last_mem_q[wr_ptr_q] <= last_pipe_q[RD_LAT-1];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
// ----------------------------------------------------------------------------
// tb_rom_stream_reader : directed bench for rom_stream_reader at RD_LAT=1 and 2
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_rom_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, loop = 1'b0, m_ready = 1'b0;
  logic [9:0]  base = '0;
  logic [10:0] len = '0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rom_stream_reader_if #(.DATA_W(8)) if1 ();
  rom_stream_reader_if #(.DATA_W(8)) if2 ();
  assign if1.m_ready = m_ready;
  assign if2.m_ready = m_ready;

  logic       en1, en2, busy1, busy2, done1, done2;
  logic [9:0] addr1, addr2;
  logic [7:0] dout1, dout2, dmid2;

  // ROM models: ROM[i] = i[7:0], latency 1 and 2
  always @(posedge clk) if (en1) dout1 <= addr1[7:0];
  always @(posedge clk) begin
    if (en2) dmid2 <= addr2[7:0];
    dout2 <= dmid2;
  end

  rom_stream_reader #(.DATA_W(8), .ADDR_W(10), .RD_LAT(1), .FIFO_D(3)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .base_addr_i(base),
    .length_i(len), .loop_i(loop), .mem_en_o(en1), .mem_addr_o(addr1),
    .mem_dout_i(dout1), .busy_o(busy1), .done_o(done1), .m_if(if1));

  rom_stream_reader #(.DATA_W(8), .ADDR_W(10), .RD_LAT(2), .FIFO_D(4)) dut2 (
    .clk(clk), .rst(rst), .start_i(start), .stop_i(stop), .base_addr_i(base),
    .length_i(len), .loop_i(loop), .mem_en_o(en2), .mem_addr_o(addr2),
    .mem_dout_i(dout2), .busy_o(busy2), .done_o(done2), .m_if(if2));

  logic [8:0] q [2][$];
  int         hs [2];
  int         outst [2];
  logic       stall [2];
  logic [8:0] prev [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_words(input int b, input int n);
    logic [9:0] a;
    for (int i = 0; i < n; i++) begin
      a = 10'(b + i);
      q[0].push_back({(i == n - 1), a[7:0]});
      q[1].push_back({(i == n - 1), a[7:0]});
    end
  endtask

  task automatic flush_q();
    q[0].delete();
    q[1].delete();
  endtask

  task automatic mon(input int k, input logic v, input logic l, input logic [7:0] d,
                     input logic en, input int fd);
    logic [8:0] w;
    if (stall[k]) chk($sformatf("hold%0d", k), {v, l, d}, {1'b1, prev[k]});
    if (en) begin
      chk($sformatf("credit%0d", k), 32'(outst[k] < fd), 32'd1);
      outst[k]++;
    end
    if (v && m_ready) begin
      hs[k]++;
      outst[k]--;
      if (q[k].size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected%0d observed=%0h expected=none", k, {l, d});
      end else begin
        w = q[k].pop_front();
        chk($sformatf("word%0d", k), {l, d}, w);
      end
    end
    stall[k] = v && !m_ready && !stop;
    prev[k]  = {l, d};
    if (stop) outst[k] = 0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        stall[k] = 1'b0;
        outst[k] = 0;
      end
    end else begin
      mon(0, if1.m_valid, if1.m_last, if1.m_data, en1, 3);
      mon(1, if2.m_valid, if2.m_last, if2.m_data, en2, 4);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      step();
      if (!busy1 && !busy2 && !done1 && !done2) ok = 1'b1;
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [3:0] pat;
    int c;
    pat = 4'b1001;
    hs[0] = 0; hs[1] = 0;

    // reset state
    repeat (3) @(posedge clk);
    mid();
    chk("rst_en", en1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_valid", {if1.m_valid, if2.m_valid}, 0);
    chk("rst_data", if1.m_data, 0);
    chk("rst_last", if1.m_last, 0);
    chk("rst_busy", {busy1, busy2}, 0);
    chk("rst_done", {done1, done2}, 0);
    step();
    rst = 1'b0;

    // basic stream, exact timing on the RD_LAT=1 instance
    step();
    base = 10'd5; len = 11'd4; loop = 1'b0; m_ready = 1'b1; start = 1'b1;
    push_words(5, 4);
    mid();
    step(); start = 1'b0; mid();
    chk("c1_busy", busy1, 1);
    chk("c1_en", en1, 1);
    chk("c1_addr", addr1, 5);
    chk("c1_valid", if1.m_valid, 0);
    step(); mid();
    chk("c2_valid", if1.m_valid, 0);
    for (int cc = 3; cc <= 6; cc++) begin
      step(); mid();
      chk($sformatf("c%0d_valid", cc), if1.m_valid, 1);
      chk($sformatf("c%0d_last", cc), if1.m_last, 32'(cc == 6));
      chk($sformatf("c%0d_busy", cc), busy1, 1);
    end
    step(); mid();
    chk("c7_done", done1, 1);
    chk("c7_busy", busy1, 0);
    chk("c7_valid", if1.m_valid, 0);
    step(); mid();
    chk("c8_done1", done1, 0);
    chk("c8_done2", done2, 1);
    wait_idle();
    chk("basic_drained", q[0].size() + q[1].size(), 0);

    // wrap with backpressure 1,0,0,1
    base = 10'd1022; len = 11'd4; start = 1'b1; m_ready = pat[0];
    push_words(1022, 4);
    for (c = 1; c < 80; c++) begin
      mid();
      step();
      start = 1'b0;
      m_ready = pat[c % 4];
      if (c > 2 && !busy1 && !busy2) break;
    end
    m_ready = 1'b1;
    wait_idle();
    chk("wrap_drained", q[0].size() + q[1].size(), 0);

    // loop mode, stop after 7 handshakes on the RD_LAT=1 instance
    step();
    hs[0] = 0; hs[1] = 0;
    base = 10'd10; len = 11'd3; loop = 1'b1; start = 1'b1;
    for (int p = 0; p < 5; p++) push_words(10, 3);
    for (c = 1; c < 40; c++) begin
      step();
      start = 1'b0;
      if (hs[0] == 6) break;
    end
    chk("loop_nogap", c, 9);
    stop = 1'b1;
    mid();
    chk("loop_7th_valid", if1.m_valid, 1);
    step(); stop = 1'b0; mid();
    chk("loop_valid_drop", {if1.m_valid, if2.m_valid}, 0);
    chk("loop_busy", {busy1, busy2}, 0);
    chk("loop_nodone", {done1, done2}, 0);
    step();
    chk("loop_hs1", hs[0], 7);
    chk("loop_hs2", hs[1], 6);
    chk("loop_nodone2", {done1, done2}, 0);
    flush_q();
    loop = 1'b0;

    // zero length
    step();
    base = 10'd7; len = 11'd0; start = 1'b1;
    mid();
    chk("z0_en", {en1, en2}, 0);
    step(); start = 1'b0; mid();
    chk("z1_done", {done1, done2}, 2'b11);
    chk("z1_busy", {busy1, busy2}, 0);
    chk("z1_en", {en1, en2}, 0);
    step(); mid();
    chk("z2_done", {done1, done2}, 0);

    // ignored start mid-transfer, then abort with a full FIFO
    step();
    base = 10'd100; len = 11'd20; m_ready = 1'b0; start = 1'b1;
    push_words(100, 20);
    for (int cc = 1; cc <= 12; cc++) begin
      step();
      start = (cc == 3);
      base  = (cc == 3) ? 10'd200 : 10'd100;
      len   = (cc == 3) ? 11'd2 : 11'd20;
    end
    mid();
    chk("full_valid", {if1.m_valid, if2.m_valid}, 2'b11);
    chk("full_noen", {en1, en2}, 0);
    chk("full_data", if1.m_data, 100);
    step(); stop = 1'b1; mid();
    chk("stop_noen", {en1, en2}, 0);
    step(); stop = 1'b0; flush_q(); mid();
    chk("abort_valid", {if1.m_valid, if2.m_valid}, 0);
    chk("abort_busy", {busy1, busy2}, 0);
    chk("abort_done", {done1, done2}, 0);
    step();
    base = 10'd300; len = 11'd3; m_ready = 1'b1; start = 1'b1;
    push_words(300, 3);
    step(); start = 1'b0;
    wait_idle();
    chk("abort_new_drained", q[0].size() + q[1].size(), 0);

    // asynchronous reset between edges
    step();
    base = 10'd50; len = 11'd8; start = 1'b1;
    push_words(50, 8);
    step(); start = 1'b0;
    repeat (3) step();
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", {if1.m_valid, if2.m_valid}, 0);
    chk("arst_busy", {busy1, busy2}, 0);
    chk("arst_en", {en1, en2}, 0);
    chk("arst_addr", addr1, 0);
    chk("arst_data", if1.m_data, 0);
    chk("arst_last", if1.m_last, 0);
    step(); flush_q();
    step(); rst = 1'b0;
    step();
    base = 10'd60; len = 11'd2; start = 1'b1;
    push_words(60, 2);
    step(); start = 1'b0;
    wait_idle();
    chk("arst_new_drained", q[0].size() + q[1].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
